// File: rtl/out_dma_if.sv
// AXI4 write-only channel bundle (AW, W, B) between a DMA master and the
// shared DMA bridge.
interface out_dma_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/out_dma.sv
// Output DMA: streams 64-bit words from the result BRAM to DDR as AXI4 INCR
// write bursts, one burst outstanding at a time, with a 2-deep BRAM prefetch.
module out_dma #(
  parameter int         AXI_ADDR_W  = 32,
  parameter int         AXI_DATA_W  = 64,
  parameter int         AXI_ID_W    = 4,
  parameter int         STREAM_ID   = 2,
  parameter int         BRAM_ADDR_W = 10,
  parameter logic [7:0] BURST_LEN   = 8'd15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [AXI_ADDR_W-1:0]  i_dst_addr,
  input  logic [31:0]            i_csr_num_beats,
  output logic                   o_done,
  output logic                   o_busy,
  output logic                   o_error,
  out_dma_if.master              m_axi,
  output logic                   o_buf_re,
  output logic [BRAM_ADDR_W-1:0] o_buf_addr,
  input  logic [AXI_DATA_W-1:0]  i_buf_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t                 r_state;
  logic [AXI_ADDR_W-1:0]  r_cur_addr;
  logic [AXI_ADDR_W-1:0]  r_awaddr;
  logic [7:0]             r_awlen;
  logic                   r_awvalid;
  logic                   r_bready;
  logic                   r_done;
  logic                   r_busy;
  logic                   r_error;
  logic [31:0]            r_total;
  logic [31:0]            r_remaining;
  logic [31:0]            r_fetched;
  logic [8:0]             r_beats;
  logic [8:0]             r_beat_cnt;
  logic [BRAM_ADDR_W-1:0] r_buf_addr;
  logic                   r_inflight;
  logic [AXI_DATA_W-1:0]  r_fifo [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;

  logic [AXI_ADDR_W-1:0]  w_aw_addr;
  logic [31:0]            w_rem_src;
  logic [8:0]             w_cap;
  logic [9:0]             w_room;
  logic [8:0]             w_beats;
  logic                   w_active;
  logic                   w_wvalid;
  logic                   w_pop;
  logic                   w_last_beat;
  logic [2:0]             w_occ;
  logic                   w_buf_re;

  // Next burst is sized from the CSR inputs at start, from the running state afterwards.
  assign w_aw_addr = (r_state == S_IDLE) ? i_dst_addr : r_cur_addr;
  assign w_rem_src = (r_state == S_IDLE) ? i_csr_num_beats : r_remaining;
  assign w_cap     = {1'b0, BURST_LEN} + 9'd1;
  assign w_room    = 10'd512 - {1'b0, w_aw_addr[11:3]};

  always_comb begin
    w_beats = w_cap;
    if (w_rem_src < {23'd0, w_beats}) w_beats = w_rem_src[8:0];
    if (w_room < {1'b0, w_beats})     w_beats = w_room[8:0];
  end

  assign w_active    = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_RESP);
  assign w_wvalid    = (r_count != 2'd0) && (r_state == S_DATA);
  assign w_pop       = w_wvalid && m_axi.wready;
  assign w_last_beat = (r_beat_cnt == r_beats - 9'd1);
  // A beat leaving this cycle frees its slot, which keeps W at one beat per cycle.
  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_buf_re    = w_active && (w_occ < 3'd2) && (r_fetched < r_total);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
      r_total     <= '0;
      r_remaining <= '0;
      r_fetched   <= '0;
      r_beats     <= '0;
      r_beat_cnt  <= '0;
      r_buf_addr  <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
    end else begin
      r_inflight <= w_buf_re;
      if (w_buf_re) begin
        r_buf_addr <= r_buf_addr + 1'b1;
        r_fetched  <= r_fetched + 32'd1;
      end
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= i_buf_rdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_total    <= i_csr_num_beats;
            r_cur_addr <= i_dst_addr;
            r_fetched  <= '0;
            r_buf_addr <= '0;
            r_beat_cnt <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_error    <= 1'b0;
            if (i_csr_num_beats == 32'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (i_dst_addr[2:0] != 3'b000) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy      <= 1'b1;
              r_awvalid   <= 1'b1;
              r_awaddr    <= w_aw_addr;
              r_awlen     <= w_beats[7:0] - 8'd1;
              r_beats     <= w_beats;
              r_remaining <= w_rem_src - {23'd0, w_beats};
              r_state     <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (m_axi.awready) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (w_last_beat) begin
              r_cur_addr <= r_cur_addr + AXI_ADDR_W'({r_beats, 3'b000});
              r_bready   <= 1'b1;
              r_state    <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (m_axi.bvalid) begin
            r_bready <= 1'b0;
            if (m_axi.bresp != 2'b00) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_remaining == 32'd0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_awvalid   <= 1'b1;
              r_awaddr    <= w_aw_addr;
              r_awlen     <= w_beats[7:0] - 8'd1;
              r_beats     <= w_beats;
              r_remaining <= w_rem_src - {23'd0, w_beats};
              r_state     <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          if (!i_start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_done        = r_done;
  assign o_busy        = r_busy;
  assign o_error       = r_error;
  assign o_buf_re      = w_buf_re;
  assign o_buf_addr    = r_buf_addr;

  assign m_axi.awid    = AXI_ID_W'(STREAM_ID);
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awlen   = r_awlen;
  assign m_axi.awsize  = 3'b011;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_fifo[r_rd_ptr];
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = w_wvalid && w_last_beat;
  assign m_axi.wvalid  = w_wvalid;
  assign m_axi.bready  = r_bready;
endmodule

// File: doc/out_dma.md
# out_dma

AXI4 write-only DMA that streams a finished result buffer from an on-chip BRAM to DDR. It is the write-side counterpart of the BSR/activation read DMAs. It reads 64-bit words from the output BRAM at one-cycle read latency and emits INCR bursts on the AXI write channels into the shared DMA bridge under its own stream ID. Control and status come from CSRs.

## Interface
- AXI_ADDR_W, 32, AXI address width
- AXI_DATA_W, 64, AXI data width; only 64 is supported
- AXI_ID_W, 4, AXI ID width
- STREAM_ID, 2, constant driven on m_axi_awid
- BRAM_ADDR_W, 10, output-BRAM word address width
- BURST_LEN, 8'd15, maximum awlen (16 beats)

Clocking and reset (already decided): one clock; reset is asynchronous and active-high.

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  level; sampled in IDLE
- dst_addr  in  AXI_ADDR_W  DDR byte address; must be 8-byte aligned
- csr_num_beats  in  32  number of 64-bit words to write
- done  out  1  transfer finished; held until start deasserts
- busy  out  1  transfer in progress
- error  out  1  misaligned dst_addr or non-OKAY bresp; sticky until next start
- m_axi_awid  out  AXI_ID_W  equals STREAM_ID
- m_axi_awaddr  out  AXI_ADDR_W  burst address
- m_axi_awlen  out  8  beats−1
- m_axi_awsize  out  3  constant 3'b011
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid / m_axi_awready  out / in  1  AW handshake
- m_axi_wdata  out  64  beat data
- m_axi_wstrb  out  8  constant 8'hFF
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid / m_axi_wready  out / in  1  W handshake
- m_axi_bid  in  AXI_ID_W  ignored
- m_axi_bresp  in  2  write response
- m_axi_bvalid / m_axi_bready  in / out  1  B handshake
- buf_re  out  1  BRAM read enable
- buf_addr  out  BRAM_ADDR_W  BRAM word address
- buf_rdata  in  64  valid the cycle after buf_re

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- **IDLE**
  - If start: latch dst_addr and csr_num_beats, set busy=1, clear error, and zero the beat/fetch counters and buf_addr.
  - If csr_num_beats==0: go to DONE with no AXI traffic.
  - If dst_addr[2:0]!=0: set error=1 and go to DONE.
  - Otherwise go to ADDR.
- **Burst length:** beats = min(BURST_LEN+1, remaining, 512−cur_addr[11:3]). The last term is the 4 KB guard. awlen = beats−1.
- **ADDR**
  - Drive awvalid=1 with awaddr/awlen stable until awready, then go to DATA.
- **DATA**
  - Emit exactly `beats` W beats.
  - wlast=1 only on the final beat.
  - cur_addr += beats*8 on the last W handshake, then go to RESP.
- **RESP**
  - bready=1.
  - On bvalid with bresp!=2'b00: set error=1 and go to DONE. No further bursts are issued.
  - On bvalid with OKAY: go to DONE if remaining==0, else ADDR.
- **DONE**
  - busy=0, done=1.
  - Return to IDLE when start==0. done clears in IDLE.
- **Prefetch**
  - 2-entry FIFO holding BRAM data.
  - buf_re=1 when (FIFO occupancy + reads in flight) < 2 and fetched < total.
  - Prefetch runs in ADDR, DATA and RESP across burst boundaries.
  - buf_addr increments per read and wraps modulo 2^BRAM_ADDR_W.
- **W channel:** wvalid = FIFO non-empty and state==DATA. wdata = FIFO head. Pop on wvalid&&wready.
- **Ordering:** W beats are never issued before the burst's AW handshake. Only one burst is outstanding at a time.
- **Reset:** rst at any time forces IDLE immediately and abandons any partial burst.
  - Outputs driven to 0: done, busy, error, awvalid, wvalid, wlast, bready, buf_re, awaddr, awlen, buf_addr and wdata.
  - FIFO emptied, counters zeroed.

## Timing
- start seen in IDLE at edge N → awvalid=1 and the first buf_re at edge N+1.
- The first wvalid is asserted the cycle after the AW handshake, provided the FIFO holds data.
- With wready held high, W sustains 1 beat/cycle within a burst.
- Per-burst overhead: one AW cycle, plus RESP cycles until bvalid.
- The last bvalid (OKAY) at edge M → done=1, busy=0 at M+1.
- Counters are 32-bit. The product beats*8 is computed at AXI_ADDR_W width.
- A wready stall holds wvalid, wdata and wlast stable. No beat is dropped or duplicated; the FIFO blocks further buf_re.

## Test plan
1. **Single burst:** dst=0x1000_0000, num_beats=16, wready=1, BRAM[i]=i → one AW with awlen=15; 16 consecutive beats with wdata=0..15 and wlast on beat 16; OKAY → done=1, error=0.
2. **Multi-burst:** num_beats=40 → AWs of awlen 15, 15, 7 at 0x1000_0000, 0x1000_0080 and 0x1000_0100; buf_addr ends at 40.
3. **4 KB guard:** dst=0x0000_0FC0, num_beats=20 → awlen=7 at 0xFC0, then awlen=11 at 0x1000.
4. **Backpressure:** awready delayed 5 cycles, wready random 50% → awvalid/awaddr held stable; wdata sequence exact and in order.
5. **Error and edge cases:**
   - SLVERR on the 2nd of 3 bursts → error=1, done=1, no 3rd AW.
   - dst=0x...004 → error=1, done=1, no AXI traffic.
   - num_beats=0 → done=1 with no AW.
6. **Reset mid-burst:** rst asserted during DATA beat 5 → all outputs 0 immediately; after release, a fresh start with num_beats=8 completes correctly from buf_addr 0.
